bch_dec_sequencer: RTL and testbench

Control sequencer for a BCH(n,k,t) decoder datapath over GF(2^M_P). Accepts one codeword frame at a time, then steps the shared decoder engines in order: syndrome, Berlekamp-Massey key equation, Chien search. Each engine gets a start pulse and returns a done flag; the block grades the outcome and returns a per-frame result. It also keeps saturating statistics counters.

---
 rtl/bch_dec_seq_pkg.sv | 28 ++
 rtl/bch_seq_watchdog.sv | 31 +++
 rtl/bch_dec_sequencer.sv | 163 ++++++++++++++++
 tb/tb_bch_dec_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_dec_seq_pkg.sv
// Shared types and constants for the BCH decoder control sequencer.
// Field-degree limits mirror the BCH datapath package.
package bch_dec_seq_pkg;

  localparam int MIN_M_C = 3;
  localparam int MAX_M_C = 16;

  localparam logic [1:0] ST_CLEAN_C  = 2'b00;
  localparam logic [1:0] ST_CORR_C   = 2'b01;
  localparam logic [1:0] ST_UNCORR_C = 2'b10;
  localparam logic [1:0] ST_TMO_C    = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SYN,
    BM,
    CHIEN,
    RESP
  } bch_seq_state_t;

  typedef enum logic [1:0] {
    CLEAN         = ST_CLEAN_C,
    CORRECTED     = ST_CORR_C,
    UNCORRECTABLE = ST_UNCORR_C,
    TIMEOUT       = ST_TMO_C
  } bch_seq_status_t;

endpackage

// File: rtl/bch_seq_watchdog.sv
// Per-stage cycle counter; expire marks the last cycle a stage may wait.
// Used by bch_dec_sequencer only when BCH_SEQ_WATCHDOG_EN is defined.
module bch_seq_watchdog #(
  parameter  int LIMIT_P = 1024,
  localparam int CW      = $clog2(LIMIT_P + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CW-1:0] LAST_C = CW'(LIMIT_P - 1);

  logic [CW-1:0] cnt;

  // clr marks cycle 0 of a stage, so cnt equals cycles elapsed afterwards
  assign expire = en && !clr && (cnt == LAST_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= CW'(1);
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bch_dec_sequencer.sv
// Frame sequencer for the BCH decoder: syndrome -> BM -> Chien -> result.
// Define BCH_SEQ_WATCHDOG_EN to build the per-stage timeout watchdog.
module bch_dec_sequencer
  import bch_dec_seq_pkg::*;
#(
  parameter  int M_P          = 8,
  parameter  int T_P          = 4,
  parameter  int ID_WIDTH_P   = 4,
  parameter  int CNT_WIDTH_P  = 16,
  parameter  int WDT_CYCLES_P = 1024,
  localparam int DW           = $clog2(2 * T_P + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frm_valid,
  output logic                   frm_ready,
  input  logic [ID_WIDTH_P-1:0]  frm_id,
  output logic                   syn_start,
  input  logic                   syn_done,
  input  logic                   syn_zero,
  output logic                   bm_start,
  input  logic                   bm_done,
  input  logic [DW-1:0]          bm_degree,
  output logic                   chien_start,
  input  logic                   chien_done,
  input  logic [DW-1:0]          chien_roots,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_WIDTH_P-1:0]  res_id,
  output logic [1:0]             res_status,
  output logic [DW-1:0]          res_nr_errors,
  output logic [CNT_WIDTH_P-1:0] cnt_frames,
  output logic [CNT_WIDTH_P-1:0] cnt_corrected,
  output logic [CNT_WIDTH_P-1:0] cnt_failed
);

  localparam logic [DW-1:0] T_C = DW'(T_P);

  if (M_P < MIN_M_C || M_P > MAX_M_C ||
      M_P * T_P >= 2 ** M_P - 1 || WDT_CYCLES_P < 2) begin : g_bad_cfg
    $error("bch_dec_sequencer: illegal parameter set");
  end

  bch_seq_state_t state;
  logic [DW-1:0]  deg_q;
  logic           wdt_exp;

`ifdef BCH_SEQ_WATCHDOG_EN
  bch_seq_watchdog #(
    .LIMIT_P (WDT_CYCLES_P)
  ) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .clr    (syn_start | bm_start | chien_start),
    .en     (state inside {SYN, BM, CHIEN}),
    .expire (wdt_exp)
  );
`else
  assign wdt_exp = 1'b0;
`endif

  assign frm_ready = (state == IDLE) && !rst;

  // A done in the start-pulse cycle is stale and deliberately ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      syn_start     <= 1'b0;
      bm_start      <= 1'b0;
      chien_start   <= 1'b0;
      res_valid     <= 1'b0;
      res_id        <= '0;
      res_status    <= CLEAN;
      res_nr_errors <= '0;
      deg_q         <= '0;
      cnt_frames    <= '0;
      cnt_corrected <= '0;
      cnt_failed    <= '0;
    end else begin
      syn_start   <= 1'b0;
      bm_start    <= 1'b0;
      chien_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frm_valid) begin
            res_id    <= frm_id;
            syn_start <= 1'b1;
            state     <= SYN;
          end
        end
        SYN: begin
          if (syn_done && !syn_start) begin
            if (syn_zero) begin
              res_status    <= CLEAN;
              res_nr_errors <= '0;
              res_valid     <= 1'b1;
              state         <= RESP;
            end else begin
              bm_start <= 1'b1;
              state    <= BM;
            end
          end else if (wdt_exp) begin
            res_status    <= TIMEOUT;
            res_nr_errors <= '0;
            res_valid     <= 1'b1;
            state         <= RESP;
          end
        end
        BM: begin
          if (bm_done && !bm_start) begin
            if (bm_degree > T_C) begin
              res_status    <= UNCORRECTABLE;
              res_nr_errors <= '0;
              res_valid     <= 1'b1;
              state         <= RESP;
            end else begin
              deg_q       <= bm_degree;
              chien_start <= 1'b1;
              state       <= CHIEN;
            end
          end else if (wdt_exp) begin
            res_status    <= TIMEOUT;
            res_nr_errors <= '0;
            res_valid     <= 1'b1;
            state         <= RESP;
          end
        end
        CHIEN: begin
          if (chien_done && !chien_start) begin
            if (chien_roots == deg_q) begin
              res_status    <= CORRECTED;
              res_nr_errors <= deg_q;
            end else begin
              res_status    <= UNCORRECTABLE;
              res_nr_errors <= '0;
            end
            res_valid <= 1'b1;
            state     <= RESP;
          end else if (wdt_exp) begin
            res_status    <= TIMEOUT;
            res_nr_errors <= '0;
            res_valid     <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
            if (~&cnt_frames)
              cnt_frames <= cnt_frames + 1'b1;
            if (res_status == ST_CORR_C && ~&cnt_corrected)
              cnt_corrected <= cnt_corrected + 1'b1;
            if (res_status[1] && ~&cnt_failed)
              cnt_failed <= cnt_failed + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_dec_sequencer.sv
// Directed self-checking bench for bch_dec_sequencer (T_P=4, watchdog 16).
// Watchdog steps run only when BCH_SEQ_WATCHDOG_EN is defined.
module tb_bch_dec_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frm_valid = 1'b0;
  logic        frm_ready;
  logic [3:0]  frm_id = '0;
  logic        syn_start;
  logic        syn_done = 1'b0;
  logic        syn_zero = 1'b0;
  logic        bm_start;
  logic        bm_done = 1'b0;
  logic [3:0]  bm_degree = '0;
  logic        chien_start;
  logic        chien_done = 1'b0;
  logic [3:0]  chien_roots = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [3:0]  res_id;
  logic [1:0]  res_status;
  logic [3:0]  res_nr_errors;
  logic [15:0] cnt_frames;
  logic [15:0] cnt_corrected;
  logic [15:0] cnt_failed;

  int errors = 0;
  int checks = 0;

  bch_dec_sequencer #(
    .M_P          (8),
    .T_P          (4),
    .ID_WIDTH_P   (4),
    .CNT_WIDTH_P  (16),
    .WDT_CYCLES_P (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frm_valid     (frm_valid),
    .frm_ready     (frm_ready),
    .frm_id        (frm_id),
    .syn_start     (syn_start),
    .syn_done      (syn_done),
    .syn_zero      (syn_zero),
    .bm_start      (bm_start),
    .bm_done       (bm_done),
    .bm_degree     (bm_degree),
    .chien_start   (chien_start),
    .chien_done    (chien_done),
    .chien_roots   (chien_roots),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_id        (res_id),
    .res_status    (res_status),
    .res_nr_errors (res_nr_errors),
    .cnt_frames    (cnt_frames),
    .cnt_corrected (cnt_corrected),
    .cnt_failed    (cnt_failed)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "bench timed out");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Accepts a frame and drives a non-zero syndrome; ends in cycle T+3
  task automatic to_bm(input logic [3:0] id);
    frm_valid = 1'b1;
    frm_id = id;
    tick();
    frm_valid = 1'b0;
    chk("syn_start", syn_start, 1);
    tick();
    syn_done = 1'b1;
    syn_zero = 1'b0;
    tick();
    syn_done = 1'b0;
    chk("bm_start", bm_start, 1);
  endtask

  task automatic do_frame(input logic [3:0] id, input logic zero,
                          input logic [3:0] deg, input logic [3:0] roots,
                          input logic [1:0] est, input logic [3:0] enr);
    chk("frm_ready_idle", frm_ready, 1);
    if (zero) begin
      frm_valid = 1'b1;
      frm_id = id;
      tick();
      frm_valid = 1'b0;
      chk("syn_start", syn_start, 1);
      tick();
      chk("syn_pulse_len", syn_start, 0);
      syn_done = 1'b1;
      syn_zero = 1'b1;
      tick();
      syn_done = 1'b0;
      syn_zero = 1'b0;
      chk("bm_skipped", bm_start, 0);
    end else begin
      to_bm(id);
      chk("rv_early", res_valid, 0);
      tick();
      bm_done = 1'b1;
      bm_degree = deg;
      tick();
      bm_done = 1'b0;
      bm_degree = '0;
      if (deg > 4'd4) begin
        chk("chien_skipped", chien_start, 0);
      end else begin
        chk("chien_start", chien_start, 1);
        tick();
        chien_done = 1'b1;
        chien_roots = roots;
        tick();
        chien_done = 1'b0;
        chien_roots = '0;
      end
    end
    chk("res_valid", res_valid, 1);
    chk("res_id", res_id, id);
    chk("res_status", res_status, est);
    chk("res_nr_errors", res_nr_errors, enr);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("rv_cleared", res_valid, 0);
    chk("frm_ready_after", frm_ready, 1);
  endtask

  initial begin
    #1;
    chk("rst_frm_ready", frm_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_syn_start", syn_start, 0);
    chk("rst_cnt_frames", cnt_frames, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", frm_ready, 1);
    tick();

    // clean frame, res_valid at T+3
    do_frame(4'd3, 1'b1, 4'd0, 4'd0, 2'b00, 4'd0);
    handshake();
    chk("cnt_frames_1", cnt_frames, 1);

    // correctable, res_valid at T+7
    do_frame(4'd5, 1'b0, 4'd3, 4'd3, 2'b01, 4'd3);
    handshake();
    chk("cnt_corrected_1", cnt_corrected, 1);

    // degree above t, Chien skipped
    do_frame(4'd6, 1'b0, 4'd5, 4'd0, 2'b10, 4'd0);
    handshake();

    // root count mismatch
    do_frame(4'd7, 1'b0, 4'd2, 4'd1, 2'b10, 4'd0);
    handshake();
    chk("cnt_failed_2", cnt_failed, 2);
    chk("cnt_frames_4", cnt_frames, 4);

    // degree exactly t, then 10 cycles of backpressure
    do_frame(4'd8, 1'b0, 4'd4, 4'd4, 2'b01, 4'd4);
    frm_valid = 1'b1;
    frm_id = 4'd15;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", res_valid, 1);
      chk("bp_status", res_status, 2'b01);
      chk("bp_id", res_id, 4'd8);
      chk("bp_nr", res_nr_errors, 4'd4);
      chk("bp_frm_ready", frm_ready, 0);
      chk("bp_no_start", syn_start, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    frm_valid = 1'b0;
    chk("bp_frm_ready_r1", frm_ready, 1);
    chk("bp_rv_cleared", res_valid, 0);

    // done coinciding with start pulse is ignored
    frm_valid = 1'b1;
    frm_id = 4'd9;
    tick();
    frm_valid = 1'b0;
    syn_done = 1'b1;
    syn_zero = 1'b1;
    tick();
    syn_done = 1'b0;
    chk("coinc_ignored", res_valid, 0);
    syn_done = 1'b1;
    tick();
    syn_done = 1'b0;
    syn_zero = 1'b0;
    chk("coinc_rv", res_valid, 1);
    chk("coinc_status", res_status, 2'b00);
    handshake();
    chk("cnt_frames_6", cnt_frames, 6);
    chk("cnt_corrected_2", cnt_corrected, 2);
    chk("cnt_failed_still2", cnt_failed, 2);

    // reset while in CHIEN
    to_bm(4'd10);
    tick();
    bm_done = 1'b1;
    bm_degree = 4'd2;
    tick();
    bm_done = 1'b0;
    chk("rstc_chien_start", chien_start, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("rstc_frm_ready", frm_ready, 0);
    chk("rstc_res_valid", res_valid, 0);
    chk("rstc_chien_start0", chien_start, 0);
    chk("rstc_res_id", res_id, 0);
    chk("rstc_cnt_frames", cnt_frames, 0);
    chk("rstc_cnt_corr", cnt_corrected, 0);
    chk("rstc_cnt_failed", cnt_failed, 0);
    tick();
    rst = 1'b0;
    tick();
    do_frame(4'd11, 1'b0, 4'd1, 4'd1, 2'b01, 4'd1);
    handshake();
    chk("rstc_cnt_frames1", cnt_frames, 1);
    chk("rstc_cnt_corr1", cnt_corrected, 1);

`ifdef BCH_SEQ_WATCHDOG_EN
    // no bm_done: timeout after 16 cycles in BM
    to_bm(4'd12);
    for (int i = 0; i < 15; i++) tick();
    chk("wdt_not_yet", res_valid, 0);
    tick();
    chk("wdt_rv", res_valid, 1);
    chk("wdt_status", res_status, 2'b11);
    chk("wdt_nr", res_nr_errors, 0);
    handshake();
    chk("wdt_cnt_failed", cnt_failed, 1);

    // done on the expiry cycle wins
    to_bm(4'd13);
    for (int i = 0; i < 15; i++) tick();
    bm_done = 1'b1;
    bm_degree = 4'd2;
    tick();
    bm_done = 1'b0;
    bm_degree = '0;
    chk("wdt_race_chien", chien_start, 1);
    chk("wdt_race_rv", res_valid, 0);
    tick();
    chien_done = 1'b1;
    chien_roots = 4'd2;
    tick();
    chien_done = 1'b0;
    chien_roots = '0;
    chk("wdt_race_status", res_status, 2'b01);
    chk("wdt_race_nr", res_nr_errors, 2);
    handshake();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
